config_loader: RTL
==================

# config_loader

Configuration loader that produces the parallel `config_in` vector consumed by the fabric's logic elements. It accepts a word stream over a valid/ready handshake and assembles the words into a configuration image. It verifies a trailing additive checksum before committing. It sits between the bitstream source (host interface or boot ROM reader) and the tile configuration inputs, and updates the fabric configuration atomically.

## Interface
- `CONFIG_WIDTH`, default 65: number of configuration bits driven; the default matches one logic element (64 LUT bits + 1 comb/seq select).
- `WORD_WIDTH`, default 8: width of each incoming stream word.
- `clock` input 1: single clock; all state changes on its rising edge.
- `nreset` input 1: reset, synchronous, active-low.
- `start` input 1: single-cycle request to begin a load; honoured only in IDLE.
- `abort` input 1: cancel the load in progress; no commit.
- `data_in` input WORD_WIDTH: stream word.
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: loader accepts a word this cycle.
- `config_out` output CONFIG_WIDTH: committed configuration image (drives the logic elements' `config_in`).
- `config_valid` output 1: `config_out` holds a checksum-verified image.
- `busy` output 1: a load is in progress (LOAD or CHECK).
- `error` output 1: the last load failed its checksum; sticky until the next accepted `start`.

## Operation
- NWORDS = ceil(CONFIG_WIDTH / WORD_WIDTH). The word counter is ceil(log2(NWORDS+1)) bits wide.
- Transfer: a word is accepted when `data_valid && data_ready` at a rising edge.
- States:
  - IDLE: `data_ready`=0. On `start`: go to LOAD, clear the counter, clear the checksum accumulator and shadow register, clear `error`. Leave `config_out` and `config_valid` unchanged.
  - LOAD: `data_ready`=1. Accepted word k (k=0..NWORDS-1) is written to shadow bits [k*WORD_WIDTH +: WORD_WIDTH]. Bits beyond CONFIG_WIDTH-1 in the last word are discarded. The full word, including discarded bits, is added to the accumulator mod 2^WORD_WIDTH. After word NWORDS-1 is accepted, go to CHECK.
  - CHECK: `data_ready`=1. The next accepted word is the checksum.
    - Equal to the accumulator: copy shadow to `config_out`, set `config_valid`=1, go to IDLE.
    - Not equal: set `error`=1, leave `config_out` and `config_valid` unchanged, go to IDLE.
- `abort` in LOAD/CHECK: go to IDLE next edge. The word presented that cycle is not accepted (`abort` masks the transfer). Outputs other than `busy`/`data_ready` are unchanged. `abort` in IDLE has no effect.
- `start` in LOAD/CHECK is ignored. `start` and `abort` together in IDLE: `start` wins.
- `data_valid` low stalls the load indefinitely; there is no timeout.
- `config_out` never shows a partial image. The fabric sees only the old or the new full image.

## Timing
- Reset (`nreset`=0 at an edge): state IDLE, `config_out`=0, `config_valid`=0, `error`=0, `busy`=0, `data_ready`=0, counter and accumulator 0. Reset mid-load discards the load.
- All outputs are registered. `busy` and `data_ready` rise on the edge after `start`.
- Minimum load is NWORDS+1 consecutive transfer cycles after the start edge.
- `config_out`/`config_valid`/`error` update on the edge that accepts the checksum word. `busy` and `data_ready` fall on the same edge.
- With no stall, a new `start` is accepted the cycle after completion.

## Test plan
- Reset: hold `nreset`=0 for 2 cycles with random inputs -> `config_out`=0, `config_valid`=0, `error`=0, `data_ready`=0.
- Good load (65/8): `start`, then words 0x01..0x09 back-to-back, then checksum 0x2D -> on that edge `config_out`=65'h1_0807060504030201, `config_valid`=1, `busy`=0. Exactly 10 transfers are accepted.
- Bad checksum: same words, checksum 0x2C -> `error`=1, `config_out` keeps its previous value, `config_valid` unchanged. A following good load clears `error` at `start` and commits.
- Partial last word: words 0x00×8, then 0xFE, then checksum 0xFE -> bit 64 = 0, `config_out`=0, `config_valid`=1. Checksum includes the discarded bits.
- Stalls, abort and ignored start:
  - Toggle `data_valid` randomly across the good-load stream -> same result as the good load.
  - Assert `abort` after word 4 -> IDLE next edge, no commit, `error`=0.
  - Pulse `start` during LOAD -> ignored; the counter does not reset.
- Reset mid-load: assert `nreset`=0 after word 6 of a load following a committed image -> `config_out`=0, `config_valid`=0, IDLE.

Source files
------------

// File: rtl/config_loader.sv
// Configuration loader: assembles a word stream into a shadow image and
// commits it to config_out only after the trailing checksum matches.
module config_loader #(
    parameter int CONFIG_WIDTH = 65,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_valid,
    output logic                    busy,
    output logic                    error
);

    localparam int NWORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W  = $clog2(NWORDS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]   acc_q, acc_d;
    logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
    logic [CONFIG_WIDTH-1:0] cfg_q, cfg_d;
    logic                    vld_q, vld_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;

    // Bits of the last word that fall past CONFIG_WIDTH are shifted out here.
    logic [CONFIG_WIDTH-1:0] word_pos;
    logic [CONFIG_WIDTH-1:0] word_mask;
    int                      shamt;

    // Next-state logic: handshake, word placement, checksum and commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        shadow_d  = shadow_q;
        cfg_d     = cfg_q;
        vld_d     = vld_q;
        err_d     = err_q;
        busy_d    = busy_q;
        shamt     = int'(cnt_q) * WORD_WIDTH;
        word_pos  = CONFIG_WIDTH'(data_in) << shamt;
        word_mask = CONFIG_WIDTH'({WORD_WIDTH{1'b1}}) << shamt;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    acc_d    = '0;
                    shadow_d = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (data_valid) begin
                    shadow_d = (shadow_q & ~word_mask) | word_pos;
                    acc_d    = acc_q + data_in;
                    if (cnt_q == LAST_WORD) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (data_valid) begin
                    if (data_in == acc_q) begin
                        cfg_d = shadow_q;
                        vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            shadow_q <= '0;
            cfg_q    <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign data_ready   = busy_q;
    assign busy         = busy_q;
    assign config_out   = cfg_q;
    assign config_valid = vld_q;
    assign error        = err_q;

endmodule
